cnn_img_sequencer: RTL
======================

Name: cnn_img_sequencer

Overview:
- Synthesizable controller that replaces bench-side image sequencing for CNN_top.
- Reads NUM_IMG images of PIX_PER_IMG 8-bit pixels from an external synchronous pixel ROM and streams them one pixel per cycle into CNN_top.
- Pulses the CNN's active-low reset between images and waits for its valid_out_6 / decision.
- Scores each decision against a label ROM and accumulates hit count and status for the whole run.

Parameters:
PIX_PER_IMG, 784, pixels per image (28x28)
NUM_IMG, 1000, images per run
ADDR_W, 20, pixel ROM address width (must hold NUM_IMG*PIX_PER_IMG-1)
LBL_AW, 10, label ROM address width
CLR_CYCLES, 2, cycles cnn_rst_n is held low before each image (>=1)
TIMEOUT, 4096, max WAIT cycles before an image is declared a miss

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  1-cycle pulse; begins a run from IDLE or DONE
px_addr  out  ADDR_W  pixel ROM address
px_rd_en  out  1  pixel ROM read enable
px_rdata  in  8  pixel ROM data, valid 1 cycle after px_rd_en
lbl_addr  out  LBL_AW  label ROM address (= image index)
lbl_rdata  in  4  label ROM data, valid 1 cycle after lbl_addr is presented
cnn_rst_n  out  1  drives CNN_top rst_n
cnn_data  out  8  drives CNN_top data_in (registered)
cnn_valid_out  in  1  CNN_top valid_out_6
cnn_decision  in  4  CNN_top decision
busy  out  1  high from start acceptance until DONE
done  out  1  high in DONE
result_valid  out  1  1-cycle pulse per scored image
last_hit  out  1  1 if last decision == label
last_decision  out  4  last captured decision
img_cnt  out  LBL_AW  images scored this run
hit_cnt  out  LBL_AW  correct decisions this run
timeout_err  out  1  sticky; any image timed out this run

Behaviour:
- Reset (rst=1 at a clk edge, including mid-run): state=IDLE, cnn_rst_n=0, cnn_data=0, px_rd_en=0, px_addr=0, lbl_addr=0, busy=0, done=0, result_valid=0, last_hit=0, last_decision=0, img_cnt=0, hit_cnt=0, timeout_err=0. Reset takes precedence over start.
- States: IDLE, CLR, STREAM, DRAIN, WAIT, SCORE, DONE.
- IDLE: cnn_rst_n=0.
  - start -> CLR. On the same edge clear img_cnt, hit_cnt and timeout_err, set base=0, set busy=1.
- CLR: cnn_rst_n=0 for exactly CLR_CYCLES cycles; lbl_addr=img_cnt presented.
  - Label is latched on the last CLR cycle.
  - -> STREAM.
- STREAM: exactly PIX_PER_IMG cycles. px_rd_en=1, px_addr=base+k for k=0..PIX_PER_IMG-1. cnn_rst_n=1.
  - cnn_data <= px_rdata each cycle, so pixel k appears on cnn_data 2 cycles after its address.
  - -> DRAIN.
- DRAIN: 2 cycles, px_rd_en=0, last two pixels delivered. -> WAIT.
- base advances by +PIX_PER_IMG per image via adder; no multiplier.
- WAIT: cnn_data holds last pixel; wait counter starts at 0.
  - cnn_valid_out=1: latch cnn_decision, set last_hit=(decision==label) -> SCORE.
  - Counter reaches TIMEOUT-1 without valid: last_hit=0, last_decision unchanged, timeout_err=1 -> SCORE.
- SCORE (1 cycle): result_valid=1. img_cnt+=1; hit_cnt+=last_hit.
  - New img_cnt==NUM_IMG: -> DONE.
  - Otherwise: -> CLR.
- DONE: done=1, busy=0, cnn_rst_n=0; counters hold.
  - start -> behaves as from IDLE: counters cleared, new run begins.
- cnn_valid_out outside WAIT is ignored. start while busy is ignored.
- Counters never wrap; NUM_IMG < 2^LBL_AW is required.

Test Plan:
1. PIX_PER_IMG=16, NUM_IMG=3; ROM pixel = address[7:0]; model CNN returns decision = lbl 20 cycles after cnn_rst_n rises.
   -> cnn_data sequences 0..15, 16..31, 32..47; 3 result_valid pulses; hit_cnt=3, img_cnt=3; done=1; timeout_err=0.
2. Same as 1, but the model returns a wrong decision for image 1.
   -> last_hit=0 on 2nd pulse only; hit_cnt=2.
3. Model never asserts valid for image 0; TIMEOUT=64.
   -> SCORE entered 64 cycles after WAIT entry; timeout_err=1; run continues; hit_cnt=2, img_cnt=3.
4. Assert rst mid-STREAM of image 1.
   -> next cycle: IDLE, all outputs at reset values, cnn_rst_n=0. A later start restarts from image 0, px_addr=0.
5. Spurious cnn_valid_out during STREAM, and start pulses while busy.
   -> no result_valid, no state change, counters unaffected.
6. start in DONE after scenario 1.
   -> counters clear on the start edge; second run produces the identical sequence and hit_cnt=3.

Source files
------------

// File: rtl/cnn_img_sequencer.sv
// cnn_img_sequencer: streams NUM_IMG images from a synchronous pixel ROM
// into CNN_top one pixel per cycle. It pulses the CNN reset between images,
// waits for each decision (or a timeout), and scores it against a label ROM.
module cnn_img_sequencer #(
    parameter int PIX_PER_IMG = 784,
    parameter int NUM_IMG     = 1000,
    parameter int ADDR_W      = 20,
    parameter int LBL_AW      = 10,
    parameter int CLR_CYCLES  = 2,
    parameter int TIMEOUT     = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] px_addr,
    output logic              px_rd_en,
    input  logic [7:0]        px_rdata,
    output logic [LBL_AW-1:0] lbl_addr,
    input  logic [3:0]        lbl_rdata,
    output logic              cnn_rst_n,
    output logic [7:0]        cnn_data,
    input  logic              cnn_valid_out,
    input  logic [3:0]        cnn_decision,
    output logic              busy,
    output logic              done,
    output logic              result_valid,
    output logic              last_hit,
    output logic [3:0]        last_decision,
    output logic [LBL_AW-1:0] img_cnt,
    output logic [LBL_AW-1:0] hit_cnt,
    output logic              timeout_err
);

    // One shared phase counter covers CLR, STREAM, DRAIN and WAIT.
    localparam int MAX_AB  = (PIX_PER_IMG > TIMEOUT) ? PIX_PER_IMG : TIMEOUT;
    localparam int MAX_CNT = (MAX_AB > CLR_CYCLES) ? MAX_AB : CLR_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0]  CLR_LAST  = CNT_W'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0]  PIX_LAST  = CNT_W'(PIX_PER_IMG - 1);
    localparam logic [CNT_W-1:0]  DRN_LAST  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PIX_STEP  = ADDR_W'(PIX_PER_IMG);
    localparam logic [LBL_AW-1:0] LBL_ZERO  = {LBL_AW{1'b0}};
    localparam logic [LBL_AW-1:0] LBL_ONE   = LBL_AW'(1);
    localparam logic [LBL_AW-1:0] NUM_IMG_C = LBL_AW'(NUM_IMG);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLR    = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_SCORE  = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [ADDR_W-1:0] base_r;
    logic [3:0]        label_r;
    logic              px_vld_r;
    logic              hit_s;
    logic              counting_s;

    // Next-state decode plus the decision-versus-label compare.
    always_comb begin
        state_s    = state_r;
        hit_s      = (cnn_decision == label_r);
        counting_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_CLR;
                else       state_s = ST_IDLE;
            end
            ST_CLR: begin
                counting_s = 1'b1;
                if (cnt_r == CLR_LAST) state_s = ST_STREAM;
                else                   state_s = ST_CLR;
            end
            ST_STREAM: begin
                counting_s = 1'b1;
                if (cnt_r == PIX_LAST) state_s = ST_DRAIN;
                else                   state_s = ST_STREAM;
            end
            ST_DRAIN: begin
                counting_s = 1'b1;
                if (cnt_r == DRN_LAST) state_s = ST_WAIT;
                else                   state_s = ST_DRAIN;
            end
            ST_WAIT: begin
                counting_s = 1'b1;
                if (cnn_valid_out || (cnt_r == TMO_LAST)) state_s = ST_SCORE;
                else                                      state_s = ST_WAIT;
            end
            ST_SCORE: begin
                if (img_cnt == NUM_IMG_C) state_s = ST_DONE;
                else                      state_s = ST_CLR;
            end
            ST_DONE: begin
                if (start) state_s = ST_CLR;
                else       state_s = ST_DONE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_s;
    end

    // Phase counter: restarts at zero on every state change.
    always_ff @(posedge clk) begin
        if (rst)                     cnt_r <= CNT_ZERO;
        else if (state_s != state_r) cnt_r <= CNT_ZERO;
        else if (counting_s)         cnt_r <= cnt_r + CNT_ONE;
        else                         cnt_r <= cnt_r;
    end

    // Datapath and registered outputs; each image's results update on SCORE entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            px_addr       <= ADDR_ZERO;
            px_rd_en      <= 1'b0;
            px_vld_r      <= 1'b0;
            lbl_addr      <= LBL_ZERO;
            label_r       <= 4'd0;
            base_r        <= ADDR_ZERO;
            cnn_rst_n     <= 1'b0;
            cnn_data      <= 8'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            result_valid  <= 1'b0;
            last_hit      <= 1'b0;
            last_decision <= 4'd0;
            img_cnt       <= LBL_ZERO;
            hit_cnt       <= LBL_ZERO;
            timeout_err   <= 1'b0;
        end else begin
            // ROM data arrives one cycle after the read; forward it on the next edge.
            px_vld_r     <= px_rd_en;
            result_valid <= 1'b0;
            if (px_vld_r) cnn_data <= px_rdata;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        img_cnt     <= LBL_ZERO;
                        hit_cnt     <= LBL_ZERO;
                        timeout_err <= 1'b0;
                        base_r      <= ADDR_ZERO;
                        lbl_addr    <= LBL_ZERO;
                    end
                end
                ST_CLR: begin
                    if (cnt_r == CLR_LAST) begin
                        label_r   <= lbl_rdata;
                        cnn_rst_n <= 1'b1;
                        px_rd_en  <= 1'b1;
                        px_addr   <= base_r;
                    end
                end
                ST_STREAM: begin
                    if (cnt_r == PIX_LAST) px_rd_en <= 1'b0;
                    else                   px_addr  <= px_addr + ADDR_ONE;
                end
                ST_WAIT: begin
                    if (cnn_valid_out) begin
                        last_decision <= cnn_decision;
                        last_hit      <= hit_s;
                        result_valid  <= 1'b1;
                        img_cnt       <= img_cnt + LBL_ONE;
                        hit_cnt       <= hit_cnt + {{(LBL_AW-1){1'b0}}, hit_s};
                    end else if (cnt_r == TMO_LAST) begin
                        last_hit     <= 1'b0;
                        timeout_err  <= 1'b1;
                        result_valid <= 1'b1;
                        img_cnt      <= img_cnt + LBL_ONE;
                    end
                end
                ST_SCORE: begin
                    cnn_rst_n <= 1'b0;
                    base_r    <= base_r + PIX_STEP;
                    if (state_s == ST_DONE) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        lbl_addr <= img_cnt;
                    end
                end
                default: begin
                    cnn_rst_n <= cnn_rst_n;
                end
            endcase
        end
    end

endmodule
